lab3_cache_mem_arbiter: RTL and testbench
=========================================

# lab3_cache_mem_arbiter

Two-port burst arbiter that lets the instruction cache and the data cache share the single test-memory port. Each cache issues its line evictions and refills as fixed-length bursts of word requests through its batch-send engine. The arbiter gives the memory port to one cache for a whole burst, forwards that burst's requests, and returns each response to the cache that issued it. It then rotates priority, so neither cache can starve the other.

## Interface
- `REQ_W`, default 77: request message width (`mem_req_4B_t`).
- `RESP_W`, default 47: response message width (`mem_resp_4B_t`).
- `BURST`, default 4: requests per burst, equal to words per cache line; legal range 1–15.
- `clk` input 1: the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `in0_req_val` / `in0_req_rdy` / `in0_req_msg`: input / output / input, widths 1 / 1 / `REQ_W`. Requester 0 (icache) request stream.
- `in0_resp_val` / `in0_resp_rdy` / `in0_resp_msg`: output / input / output, widths 1 / 1 / `RESP_W`. Requester 0 response stream.
- `in1_req_*` / `in1_resp_*`: same set of ports for requester 1 (dcache).
- `mem_req_val` output 1, `mem_req_rdy` input 1, `mem_req_msg` output `REQ_W`: memory request stream.
- `mem_resp_val` input 1, `mem_resp_rdy` output 1, `mem_resp_msg` input `RESP_W`: memory response stream.
- `grant` output 2: one-hot owner of the memory port; 00 when idle.

## Operation
- **States:**
  - IDLE: no owner.
  - BURST: the owner holds the port.
- **Counters:**
  - `issued` counts request handshakes in the current burst.
  - `rcvd` counts response handshakes in the current burst.
  - Both are 4 bits, saturate-free, and clear when the state enters BURST.
- **Priority pointer `prio`:** 1 bit, reset 0.
- **IDLE, one valid requester:** that requester is granted.
- **IDLE, both requesters valid:** `prio` wins.
- **Grant timing:** the grant registers at the clock edge, and the state moves to BURST. With no valid requester the state stays in IDLE.
- **BURST, requests:** requests pass through combinationally while `issued < BURST`.
  - `mem_req_val` = owner `req_val`.
  - `mem_req_msg` = owner `req_msg`.
  - Owner `req_rdy` = `mem_req_rdy`.
  - The non-owner `req_rdy` is 0.
- **BURST, responses:** responses are accepted while `rcvd < issued`.
  - `mem_resp_rdy` = owner `resp_rdy`.
  - Owner `resp_val` = `mem_resp_val`.
  - Both `inX_resp_msg` outputs carry `mem_resp_msg` unconditionally; only the `val` is steered.
- **Back-pressure:** a response presented while `rcvd == issued` (including any response in IDLE) is back-pressured with `mem_resp_rdy` = 0 and is never dropped.
- **Burst completion:** when `issued == BURST` and the response handshake takes `rcvd` to `BURST`, the state goes to IDLE and `prio` is set to the non-owner.
- **Request types:** reads and writes are treated identically. Each request produces exactly one response, in order.
- **Request messages:** request messages are never modified.
- **Non-owner stall:** a non-owner valid request simply stalls; it is not required to hold its message stable until `rdy`, but the caches do.

## Timing
- **Reset values:** every output is 0 during and after reset, until the first grant. This covers all `rdy`/`val` outputs, `grant` = 00, state IDLE, `prio` = 0 and both counters 0.
- **Grant latency:** a request raised in an IDLE cycle at edge t is forwarded to memory in cycle t+1; there is no request forwarding in IDLE.
- **Burst gap:** one dead cycle (IDLE) between consecutive bursts.
  - The last response handshake occurs in cycle c.
  - The next burst's first request can handshake in cycle c+2.
- **Same-cycle events:**
  - A request handshake and a response handshake in the same cycle both count.
  - The response counts only if `rcvd < issued` held before that edge.
  - Memory latency is at least one cycle.
- **Back-to-back handshakes:** request and response handshakes may occur on every cycle; there are no internal bubbles inside a burst.
- **Asynchronous reset mid-burst:**
  - Outputs drop to their reset values immediately, not at the next edge.
  - State goes to IDLE and counters clear.
  - In-flight responses are the memory's responsibility: memory is also reset.
- **Combinational paths:**
  - The only paths are the req/resp pass-throughs gated by registered state.
  - There is no `rdy`→`val` loop: `mem_req_val` does not depend on `mem_req_rdy`.

## Test plan
- **Single requester:** hold `in0_req_val`=1 for 4 requests with addresses 0x1000, 0x1004, 0x1008, 0x100C; memory returns after 1 cycle with `mem_req_rdy`=1. Required: `grant`=01 from cycle 1; 4 consecutive `mem_req` handshakes; 4 responses delivered on `in0_resp`; `grant`=00 after the 4th response; `in1_resp_val` never set.
- **Tie and rotation:** both requesters valid from reset release. Required: `in0` owns the first burst. After it, `in1` owns the next burst even though `in0_req_val` stays 1. A third burst goes back to `in0`.
- **Back-pressure:** `mem_req_rdy` toggles 1,0,1,0 and `in0_resp_rdy`=0 for 3 cycles. Required: the request count stays 4; `mem_resp_rdy` = 0 during the stall; no response lost; the burst ends only after the 4th response handshake.
- **Early response guard:** drive `mem_resp_val`=1 while IDLE. Required: `mem_resp_rdy`=0, no `inX_resp_val` asserted, state stays IDLE.
- **Reset mid-burst:** assert `reset`=0 after 2 requests of a burst. Required: all outputs 0 the same cycle. After release, a new `in1` request is granted with `grant`=10 and `issued` starting at 0.
- **Overlap:** memory latency 1 with `mem_req_rdy`=1, so request n+1 and response n handshake in the same cycle. Required: the burst completes in 5 cycles after the grant, followed by one IDLE cycle.

Source files
------------

// File: rtl/lab3_cache_mem_arbiter.sv
// Burst arbiter sharing one memory port between the icache (requester 0) and the
// dcache (requester 1): one whole burst per grant, priority rotates after each burst.
module lab3_cache_mem_arbiter #(
  parameter int REQ_W  = 77,
  parameter int RESP_W = 47,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              in0_req_val,
  output logic              in0_req_rdy,
  input  logic [REQ_W-1:0]  in0_req_msg,
  output logic              in0_resp_val,
  input  logic              in0_resp_rdy,
  output logic [RESP_W-1:0] in0_resp_msg,

  input  logic              in1_req_val,
  output logic              in1_req_rdy,
  input  logic [REQ_W-1:0]  in1_req_msg,
  output logic              in1_resp_val,
  input  logic              in1_resp_rdy,
  output logic [RESP_W-1:0] in1_resp_msg,

  output logic              mem_req_val,
  input  logic              mem_req_rdy,
  output logic [REQ_W-1:0]  mem_req_msg,
  input  logic              mem_resp_val,
  output logic              mem_resp_rdy,
  input  logic [RESP_W-1:0] mem_resp_msg,

  output logic [1:0]        grant
);

  localparam logic [3:0] BURST_LEN = 4'(BURST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic             prio_q;
  logic [1:0]       grant_q;
  logic [3:0]       issued_q;
  logic [3:0]       rcvd_q;
  logic [3:0]       issued_d;
  logic [3:0]       rcvd_d;

  logic             req_open;
  logic             resp_open;
  logic             own_req_val;
  logic             own_resp_rdy;
  logic [REQ_W-1:0] own_req_msg;
  logic             req_hs;
  logic             resp_hs;
  logic             pick;
  logic             burst_done;

  // All pass-throughs are gated by registered state only, so no rdy->val loop exists.
  assign req_open     = (state_q == ST_BURST) && (issued_q < BURST_LEN);
  assign resp_open    = (state_q == ST_BURST) && (rcvd_q < issued_q);

  assign own_req_val  = owner_q ? in1_req_val  : in0_req_val;
  assign own_req_msg  = owner_q ? in1_req_msg  : in0_req_msg;
  assign own_resp_rdy = owner_q ? in1_resp_rdy : in0_resp_rdy;

  assign mem_req_val  = req_open & own_req_val;
  assign mem_req_msg  = req_open ? own_req_msg : '0;
  assign in0_req_rdy  = req_open & ~owner_q & mem_req_rdy;
  assign in1_req_rdy  = req_open &  owner_q & mem_req_rdy;

  assign mem_resp_rdy = resp_open & own_resp_rdy;
  assign in0_resp_val = resp_open & ~owner_q & mem_resp_val;
  assign in1_resp_val = resp_open &  owner_q & mem_resp_val;
  assign in0_resp_msg = mem_resp_msg;
  assign in1_resp_msg = mem_resp_msg;

  assign grant        = grant_q;

  assign req_hs       = mem_req_val & mem_req_rdy;
  assign resp_hs      = mem_resp_val & mem_resp_rdy;
  assign pick         = (in0_req_val & in1_req_val) ? prio_q : in1_req_val;

  always_comb begin
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    if (req_hs) begin
      issued_d = issued_q + 4'd1;
    end
    if (resp_hs) begin
      rcvd_d = rcvd_q + 4'd1;
    end
  end

  assign burst_done = (issued_q == BURST_LEN) && resp_hs && (rcvd_d == BURST_LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      grant_q  <= 2'b00;
      issued_q <= 4'd0;
      rcvd_q   <= 4'd0;
    end else if (state_q == ST_IDLE) begin
      if (in0_req_val | in1_req_val) begin
        state_q  <= ST_BURST;
        owner_q  <= pick;
        grant_q  <= pick ? 2'b10 : 2'b01;
        issued_q <= 4'd0;
        rcvd_q   <= 4'd0;
      end
    end else begin
      issued_q <= issued_d;
      rcvd_q   <= rcvd_d;
      if (burst_done) begin
        state_q <= ST_IDLE;
        grant_q <= 2'b00;
        prio_q  <= ~owner_q;
      end
    end
  end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Scoreboard bench for lab3_cache_mem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a burst-level model and a per-requester response queue.
`timescale 1ns/1ps
module tb_lab3_cache_mem_arbiter;
  localparam int REQ_W  = 77;
  localparam int RESP_W = 47;
  localparam int BURST  = 4;
  localparam logic [RESP_W-1:0] RESP_MASK = 47'h1234_5678_9ABC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [1:0]          rq_val;
  logic [REQ_W-1:0]    rq_msg [2];
  logic [1:0]          rs_rdy;
  logic                mem_req_rdy;
  logic                mem_resp_val;
  logic [RESP_W-1:0]   mem_resp_msg;

  wire                 in0_req_rdy, in1_req_rdy, in0_resp_val, in1_resp_val;
  wire [RESP_W-1:0]    in0_resp_msg, in1_resp_msg;
  wire                 mem_req_val, mem_resp_rdy;
  wire [REQ_W-1:0]     mem_req_msg;
  wire [1:0]           grant;
  wire [1:0]           rq_rdy = {in1_req_rdy, in0_req_rdy};
  wire [1:0]           rs_val = {in1_resp_val, in0_resp_val};

  lab3_cache_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .in0_req_val(rq_val[0]), .in0_req_rdy(in0_req_rdy), .in0_req_msg(rq_msg[0]),
    .in0_resp_val(in0_resp_val), .in0_resp_rdy(rs_rdy[0]), .in0_resp_msg(in0_resp_msg),
    .in1_req_val(rq_val[1]), .in1_req_rdy(in1_req_rdy), .in1_req_msg(rq_msg[1]),
    .in1_resp_val(in1_resp_val), .in1_resp_rdy(rs_rdy[1]), .in1_resp_msg(in1_resp_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .grant(grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Memory model: response payload is a fixed scramble of the request it answers.
  function automatic logic [RESP_W-1:0] resp_of(input logic [REQ_W-1:0] r);
    logic [REQ_W-1:0] t;
    t = r ^ (r >> 31);
    return t[RESP_W-1:0] ^ RESP_MASK;
  endfunction

  // Scoreboard queues and handshake flags shared between driver and monitor.
  logic [RESP_W-1:0] exp_q0 [$];
  logic [RESP_W-1:0] exp_q1 [$];
  logic [RESP_W-1:0] mq [$];
  int                mq_at [$];
  bit   [1:0]        f_req_hs;
  bit                f_mreq_hs, f_mresp_hs;
  logic [REQ_W-1:0]  f_mreq_msg;

  // Burst-level reference model state.
  bit   m_busy, m_owner, m_prio;
  int   m_reqs, m_resps, m_len;
  int   cur_dut_reqs, last_len, last_reqs;
  int   owners_seen [$];
  int   resp_cnt [2];
  logic own_val, e_req_open, e_resp_open, e_mreq_val, e_mresp_rdy;
  logic [1:0] e_grant, e_rq_rdy, e_rs_val;

  initial begin
    m_busy = 0; m_owner = 0; m_prio = 0; m_reqs = 0; m_resps = 0; m_len = 0;
    cur_dut_reqs = 0; last_len = 0; last_reqs = 0; resp_cnt[0] = 0; resp_cnt[1] = 0;
    f_req_hs = 0; f_mreq_hs = 0; f_mresp_hs = 0; f_mreq_msg = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 0; m_owner = 0; m_prio = 0; m_reqs = 0; m_resps = 0;
        cur_dut_reqs = 0; f_req_hs = 0; f_mreq_hs = 0; f_mresp_hs = 0;
      end else begin
        own_val     = m_owner ? rq_val[1] : rq_val[0];
        e_req_open  = m_busy && (m_reqs < BURST);
        e_resp_open = m_busy && (m_resps < m_reqs);
        e_grant     = !m_busy ? 2'b00 : (m_owner ? 2'b10 : 2'b01);
        e_mreq_val  = e_req_open && own_val;
        e_rq_rdy    = {e_req_open && m_owner && mem_req_rdy, e_req_open && !m_owner && mem_req_rdy};
        e_mresp_rdy = e_resp_open && rs_rdy[m_owner];
        e_rs_val    = {e_resp_open && m_owner && mem_resp_val, e_resp_open && !m_owner && mem_resp_val};

        chk("grant", grant, e_grant);
        chk("mem_req_val", mem_req_val, e_mreq_val);
        chk("req_rdy", rq_rdy, e_rq_rdy);
        chk("mem_resp_rdy", mem_resp_rdy, e_mresp_rdy);
        chk("resp_val", rs_val, e_rs_val);
        chk("in0_resp_msg", in0_resp_msg, mem_resp_msg);
        chk("in1_resp_msg", in1_resp_msg, mem_resp_msg);
        if (e_mreq_val) chk("mem_req_msg", mem_req_msg, rq_msg[m_owner]);

        for (int x = 0; x < 2; x++) begin
          if (rs_val[x] && rs_rdy[x]) begin
            resp_cnt[x]++;
            if ((x == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              chk($sformatf("resp%0d_unexpected", x), 1, 0);
            end else if (x == 0) begin
              chk("resp0_msg", in0_resp_msg, exp_q0[0]);
              exp_q0.delete(0);
            end else begin
              chk("resp1_msg", in1_resp_msg, exp_q1[0]);
              exp_q1.delete(0);
            end
          end
        end

        f_req_hs   = rq_val & rq_rdy;
        f_mreq_hs  = mem_req_val && mem_req_rdy;
        f_mreq_msg = mem_req_msg;
        f_mresp_hs = mem_resp_val && mem_resp_rdy;

        if (!m_busy) begin
          if (rq_val != 2'b00) begin
            m_owner = (rq_val == 2'b11) ? m_prio : rq_val[1];
            m_busy = 1; m_reqs = 0; m_resps = 0; m_len = 0; cur_dut_reqs = 0;
            owners_seen.push_back(int'(m_owner));
          end
        end else begin
          m_len++;
          if (mem_req_val && mem_req_rdy) cur_dut_reqs++;
          if (e_mreq_val && mem_req_rdy) m_reqs++;
          if (e_mresp_rdy && mem_resp_val) m_resps++;
          if (m_resps == BURST) begin
            m_busy = 0; m_prio = !m_owner;
            last_len = m_len; last_reqs = cur_dut_reqs; cur_dut_reqs = 0;
          end
        end
      end
    end
  end

  // Driver state: requester engines and memory behaviour.
  int          cyc = 0;
  int          words_left [2];
  bit          dir_addr [2];
  logic [31:0] next_addr [2];
  int          mem_mode, lat_max;
  bit          mem_tog, mem_override, rand_resp_rdy;

  task automatic new_msg(input int x);
    logic [REQ_W-1:0] m;
    m = REQ_W'({$urandom(), $urandom(), $urandom()});
    if (dir_addr[x]) begin
      m[31:0] = next_addr[x];
      next_addr[x] = next_addr[x] + 32'd4;
    end
    rq_msg[x] = m;
  endtask

  task automatic load(input int x, input int n);
    words_left[x] = n;
    new_msg(x);
    rq_val[x] = 1'b1;
  endtask

  task automatic clear_all();
    mq.delete(); mq_at.delete(); exp_q0.delete(); exp_q1.delete();
    words_left[0] = 0; words_left[1] = 0; rq_val = 2'b00;
    mem_resp_val = 1'b0; mem_resp_msg = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (!reset) return;
    if (f_mresp_hs && mq.size() > 0) begin mq.delete(0); mq_at.delete(0); end
    if (f_mreq_hs) begin
      mq.push_back(resp_of(f_mreq_msg));
      mq_at.push_back(cyc + $urandom_range(0, lat_max - 1));
    end
    if (!mem_override) begin
      mem_resp_val = 1'b0;
      mem_resp_msg = '0;
      if (mq.size() > 0) begin
        mem_resp_val = (cyc >= mq_at[0]);
        mem_resp_msg = mq[0];
      end
    end
    case (mem_mode)
      0: mem_req_rdy = 1'b1;
      1: begin mem_tog = ~mem_tog; mem_req_rdy = mem_tog; end
      default: mem_req_rdy = ($urandom_range(0, 3) != 0);
    endcase
    for (int x = 0; x < 2; x++) begin
      if (f_req_hs[x]) begin
        if (x == 0) exp_q0.push_back(resp_of(rq_msg[0]));
        else        exp_q1.push_back(resp_of(rq_msg[1]));
        words_left[x]--;
        if (words_left[x] > 0) new_msg(x);
      end
      rq_val[x] = (words_left[x] > 0);
      if (rand_resp_rdy) rs_rdy[x] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_done(input string nm, input int bound);
    int n;
    n = 0;
    while (!(words_left[0] == 0 && words_left[1] == 0 && !m_busy && mq.size() == 0) && n < bound) begin
      step();
      n++;
    end
    chk({nm, "_in_time"}, n < bound, 1);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_mem_req_val"}, mem_req_val, 0);
    chk({nm, "_mem_req_msg"}, mem_req_msg, 0);
    chk({nm, "_mem_resp_rdy"}, mem_resp_rdy, 0);
    chk({nm, "_req_rdy"}, rq_rdy, 0);
    chk({nm, "_resp_val"}, rs_val, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0, r1, n;
    reset = 1'b0; rq_val = 2'b00; rs_rdy = 2'b11; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; mem_resp_msg = '0;
    rq_msg[0] = '0; rq_msg[1] = '0; words_left[0] = 0; words_left[1] = 0;
    dir_addr[0] = 0; dir_addr[1] = 0; next_addr[0] = 0; next_addr[1] = 0;
    mem_mode = 0; lat_max = 1; mem_tog = 0; mem_override = 0; rand_resp_rdy = 0;

    // Reset state
    repeat (3) step();
    chk_outputs_zero("reset");
    reset = 1'b1;
    step(); step();

    // Single requester, latency 1, full overlap of request n+1 and response n
    dir_addr[0] = 1; next_addr[0] = 32'h1000;
    r0 = resp_cnt[0]; r1 = resp_cnt[1]; n0 = owners_seen.size();
    load(0, 4);
    step(); #1;
    chk("single_grant_cycle1", grant, 2'b01);
    wait_done("single", 50);
    chk("single_owner", (owners_seen.size() > n0) ? owners_seen[n0] : -1, 0);
    chk("single_req_count", last_reqs, 4);
    chk("single_burst_cycles", last_len, 5);
    chk("single_resp0_count", resp_cnt[0] - r0, 4);
    chk("single_resp1_count", resp_cnt[1] - r1, 0);
    chk("single_idle_after", grant, 2'b00);
    dir_addr[0] = 0;

    // Tie and rotation from reset release
    reset = 1'b0; clear_all();
    step();
    load(0, 2 * BURST); load(1, BURST);
    step();
    reset = 1'b1;
    n0 = owners_seen.size();
    wait_done("rotate", 200);
    chk("rotate_bursts", owners_seen.size() - n0, 3);
    if (owners_seen.size() >= n0 + 3) begin
      chk("rotate_first", owners_seen[n0], 0);
      chk("rotate_second", owners_seen[n0 + 1], 1);
      chk("rotate_third", owners_seen[n0 + 2], 0);
    end

    // Back-pressure on both request and response sides
    mem_mode = 1; mem_tog = 0; rs_rdy[0] = 1'b0; r0 = resp_cnt[0];
    load(0, 4);
    step();
    repeat (3) begin
      step(); #1;
      chk("bp_mem_resp_rdy", mem_resp_rdy, 0);
      #1;
    end
    rs_rdy[0] = 1'b1;
    wait_done("bp", 100);
    chk("bp_req_count", last_reqs, 4);
    chk("bp_resp_count", resp_cnt[0] - r0, 4);
    chk("bp_queue_empty", exp_q0.size(), 0);
    mem_mode = 0;

    // Response presented while idle must be held off
    step();
    mem_override = 1; mem_resp_val = 1'b1; mem_resp_msg = RESP_W'($urandom());
    repeat (3) begin
      step(); #1;
      chk("early_mem_resp_rdy", mem_resp_rdy, 0);
      chk("early_resp_val", rs_val, 0);
      chk("early_grant", grant, 0);
    end
    mem_resp_val = 1'b0; mem_override = 0;
    step();

    // Asynchronous reset after two requests of a burst
    load(0, 4);
    n = 0;
    while (cur_dut_reqs < 2 && n < 20) begin step(); n++; end
    chk("rst_two_reqs_in_time", n < 20, 1);
    #1 reset = 1'b0;
    #1 chk_outputs_zero("midrst");
    clear_all();
    step(); step();
    reset = 1'b1;
    n0 = owners_seen.size();
    load(1, 4);
    step(); #1;
    chk("midrst_grant", grant, 2'b10);
    wait_done("midrst", 50);
    chk("midrst_owner", (owners_seen.size() > n0) ? owners_seen[n0] : -1, 1);
    chk("midrst_req_count", last_reqs, 4);

    // Randomized traffic
    mem_mode = 2; lat_max = 3; rand_resp_rdy = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int x = 0; x < 2; x++) begin
        if (words_left[x] == 0 && $urandom_range(0, 7) == 0) load(x, BURST * $urandom_range(1, 2));
      end
      step();
    end
    wait_done("random_drain", 3000);
    chk("random_q0_empty", exp_q0.size(), 0);
    chk("random_q1_empty", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
